// File: rtl/vga_arb_pkg.sv
// Shared types and default widths for the VGA plot-port arbiter.
// Optional forced-release support is enabled by defining VGA_ARB_TIMEOUT_EN.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Default geometry: 320x240 screen, 3-bit colour
  localparam int VGA_X_W = 9;
  localparam int VGA_Y_W = 8;
  localparam int VGA_C_W = 3;

  // Round-robin successor of an index within n requesters
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W:0]   sum  [N_REQ];
  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester examined at priority rank gi
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (IDX_W+1)'(N_REQ)) ?
                      IDX_W'(sum[gi] - (IDX_W+1)'(N_REQ)) : sum[gi][IDX_W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  // Scan from lowest priority upward so the highest-priority hit is written last
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx   = cand[k];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA adapter plot port shared by the animation engines.
// Define VGA_ARB_TIMEOUT_EN to force release of a grant held for MAX_HOLD cycles.
module vga_plot_arbiter
  import vga_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int X_W      = VGA_X_W,
  parameter int Y_W      = VGA_Y_W,
  parameter int C_W      = VGA_C_W,
  parameter int MAX_HOLD = 2000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*X_W-1:0] pix_x,
  input  logic [N_REQ*Y_W-1:0] pix_y,
  input  logic [N_REQ*C_W-1:0] pix_colour,
  input  logic [N_REQ-1:0]   pix_plot,
  output logic [N_REQ-1:0]   grant,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [C_W-1:0]     colour,
  output logic               plot,
  output logic               busy,
  output logic               timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("vga_plot_arbiter: N_REQ must be 2..8 and MAX_HOLD >= 1");
  end

  arb_state_e       state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [X_W-1:0]   x_reg;
  logic [Y_W-1:0]   y_reg;
  logic [C_W-1:0]   colour_reg;
  logic             plot_reg;
  logic             busy_reg;

  logic [X_W-1:0]   px_arr [N_REQ];
  logic [Y_W-1:0]   py_arr [N_REQ];
  logic [C_W-1:0]   pc_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign px_arr[gi] = pix_x[gi*X_W +: X_W];
    assign py_arr[gi] = pix_y[gi*Y_W +: Y_W];
    assign pc_arr[gi] = pix_colour[gi*C_W +: C_W];
  end

  logic             owner_req;
  logic             force_rel;
  logic [N_REQ-1:0] req_eff;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  assign owner_req   = req[owner_reg];
  assign rr_ptr_next = IDX_W'(rr_next(32'(owner_reg), N_REQ));

`ifdef VGA_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [N_REQ-1:0]  lock_reg;
  logic              timeout_reg;

  // A timed-out engine stays locked out until it lets go of req
  assign req_eff   = req & ~lock_reg;
  assign force_rel = owner_req && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign timeout   = timeout_reg;
`else
  assign req_eff   = req;
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_eff),
    .rr_ptr (rr_ptr_reg),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef VGA_ARB_TIMEOUT_EN
      hold_cnt_reg <= '0;
      lock_reg     <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
`ifdef VGA_ARB_TIMEOUT_EN
      timeout_reg <= 1'b0;
      lock_reg    <= lock_reg & req;
`endif
      case (state_reg)
        ST_IDLE: begin
          plot_reg <= 1'b0;
          if (pick_valid) begin
            grant_reg <= N_REQ'(1) << pick_idx;
            owner_reg <= pick_idx;
            busy_reg  <= 1'b1;
            state_reg <= ST_GRANT;
`ifdef VGA_ARB_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!owner_req || force_rel) begin
            // x/y/colour keep the last pixel; only plot drops
            grant_reg  <= '0;
            plot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= ST_GAP;
`ifdef VGA_ARB_TIMEOUT_EN
            if (force_rel) begin
              timeout_reg          <= 1'b1;
              lock_reg[owner_reg]  <= 1'b1;
            end
`endif
          end else begin
            x_reg      <= px_arr[owner_reg];
            y_reg      <= py_arr[owner_reg];
            colour_reg <= pc_arr[owner_reg];
            plot_reg   <= pix_plot[owner_reg];
`ifdef VGA_ARB_TIMEOUT_EN
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
`endif
          end
        end
        ST_GAP: begin
          plot_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          grant_reg <= '0;
          plot_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant  = grant_reg;
  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: grant ordering, pixel latency, gap cycle,
// mid-grant reset and the VGA_ARB_TIMEOUT_EN / default hold behaviour.
module tb_vga_plot_arbiter;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*XW-1:0] pix_x = '0;
  logic [N*YW-1:0] pix_y = '0;
  logic [N*CW-1:0] pix_colour = '0;
  logic [N-1:0]   pix_plot = '0;
  logic [N-1:0]   grant;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [CW-1:0]  colour;
  logic           plot;
  logic           busy;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  vga_plot_arbiter #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .MAX_HOLD(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_plot(pix_plot),
    .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int e, input int xv, input int yv, input int cv, input int pv);
    pix_x[e*XW +: XW]      = XW'(xv);
    pix_y[e*YW +: YW]      = YW'(yv);
    pix_colour[e*CW +: CW] = CW'(cv);
    pix_plot[e]            = pv[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] exp_g;
  int           seen_to;

  initial begin
    // ---------------- Test 1: reset state and a single transfer
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_x", 32'(x), 0);
    check_eq("rst_y", 32'(y), 0);
    check_eq("rst_colour", 32'(colour), 0);
    check_eq("rst_plot", 32'(plot), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_timeout", 32'(timeout), 0);

    reset = 1'b0;
    set_pix(0, 50, 165, 2, 1);
    req = 4'b0001;
    tick();
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_plot_pre", 32'(plot), 0);
    tick();
    check_eq("t1_x", 32'(x), 50);
    check_eq("t1_y", 32'(y), 165);
    check_eq("t1_colour", 32'(colour), 2);
    check_eq("t1_plot", 32'(plot), 1);
    req = 4'b0000;
    tick();
    check_eq("t1_rel_grant", 32'(grant), 0);
    check_eq("t1_rel_plot", 32'(plot), 0);
    check_eq("t1_rel_busy", 32'(busy), 0);
    check_eq("t1_hold_x", 32'(x), 50);

    // ---------------- Test 2: round-robin order with all engines requesting
    do_reset();
    for (int e = 0; e < N; e++) set_pix(e, 10 + e, 20 + e, e, 1);
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % N;
      exp_g = 4'b0001 << e;
      check_eq($sformatf("t2_grant%0d", g), 32'(grant), 32'(exp_g));
      for (int p = 0; p < 16; p++) tick();
      check_eq($sformatf("t2_x%0d", g), 32'(x), 32'(10 + e));
      check_eq($sformatf("t2_plot%0d", g), 32'(plot), 1);
      req[e] = 1'b0;
      tick();
      check_eq($sformatf("t2_gap_grant%0d", g), 32'(grant), 0);
      check_eq($sformatf("t2_gap_plot%0d", g), 32'(plot), 0);
      req[e] = 1'b1;
      tick();
      check_eq($sformatf("t2_idle_grant%0d", g), 32'(grant), 0);
      check_eq($sformatf("t2_idle_plot%0d", g), 32'(plot), 0);
      tick();
    end

    // ---------------- Test 3: no preemption while engine 1 owns
    do_reset();
    set_pix(1, 11, 21, 1, 1);
    set_pix(2, 200, 100, 5, 1);
    req = 4'b0010;
    tick();
    check_eq("t3_grant", 32'(grant), 32'h2);
    req = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t3_keep_grant%0d", k), 32'(grant), 32'h2);
      check_eq($sformatf("t3_keep_x%0d", k), 32'(x), 11);
    end
    req = 4'b0100;
    tick();
    check_eq("t3_gap_grant", 32'(grant), 0);
    check_eq("t3_gap_x", 32'(x), 11);
    tick();
    check_eq("t3_idle_grant", 32'(grant), 0);
    tick();
    check_eq("t3_grant2", 32'(grant), 32'h4);
    tick();
    check_eq("t3_x2", 32'(x), 200);
    check_eq("t3_plot2", 32'(plot), 1);

    // ---------------- Test 4: reset in the middle of a grant
    reset = 1'b1;
    tick();
    check_eq("t4_grant", 32'(grant), 0);
    check_eq("t4_x", 32'(x), 0);
    check_eq("t4_y", 32'(y), 0);
    check_eq("t4_colour", 32'(colour), 0);
    check_eq("t4_plot", 32'(plot), 0);
    check_eq("t4_busy", 32'(busy), 0);
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    check_eq("t4_after_grant", 32'(grant), 32'h1);

    // ---------------- Test 5/6: engine 3 stuck requesting
    do_reset();
    set_pix(3, 300, 200, 7, 1);
    req = 4'b1000;
    tick();
    check_eq("t5_grant", 32'(grant), 32'h8);
    req = 4'b1001;
`ifdef VGA_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq($sformatf("t5_hold%0d", k), 32'(grant), 32'h8);
      check_eq($sformatf("t5_no_to%0d", k), 32'(timeout), 0);
    end
    tick();
    check_eq("t5_rel_grant", 32'(grant), 0);
    check_eq("t5_timeout", 32'(timeout), 1);
    check_eq("t5_rel_plot", 32'(plot), 0);
    tick();
    check_eq("t5_to_pulse", 32'(timeout), 0);
    check_eq("t5_idle_grant", 32'(grant), 0);
    tick();
    check_eq("t5_next_grant", 32'(grant), 32'h1);
`else
    seen_to = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (timeout !== 1'b0) seen_to++;
      if (k % 100 == 0) check_eq($sformatf("t6_hold%0d", k), 32'(grant), 32'h8);
    end
    check_eq("t6_timeout_seen", 32'(seen_to), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
